// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer
// Single-clock command sequencer for the calculator datapath. Takes STORE /
// MUL / SHOW / CLEAR commands, keeps the running total and the pending
// operand, runs a shift-add multiply and a double-dabble binary-to-BCD
// conversion, and raises a sticky overflow flag against the display limit.
//
// Optional build macro CALC_SEG7_EN adds seg_out, a combinational 7-segment
// decode of bcd_out (gfedcba per digit, leading zeros blanked).
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; op and operand are
// captured on that edge, so the requester may change them afterwards. A
// request held while busy is simply not taken until the sequencer is idle.
//
// Debug: the FSM state is the internal signal "state" (enum state_t).
module calc_cmd_sequencer #(
    parameter int IN_W   = 14,
    parameter int ACC_W  = 17,
    parameter int LIMIT  = 99999,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [IN_W-1:0]     cmd_operand,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ACC_W-1:0]    total,
    output logic [ACC_W-1:0]    pending,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                bcd_valid
`ifdef CALC_SEG7_EN
    ,
    output logic [7*DIGITS-1:0] seg_out
`endif
);

    // Product register wide enough that pending*operand can never wrap.
    localparam int PW      = ACC_W + IN_W;
    // One extra bit so total+pending never wraps before the limit compare.
    localparam int SW      = ACC_W + 1;
    localparam int BW      = 4 * DIGITS;
    localparam int CNT_MAX = (IN_W > ACC_W) ? IN_W : ACC_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SW-1:0]    LIMIT_S  = SW'(LIMIT);
    localparam logic [PW-1:0]    LIMIT_P  = PW'(LIMIT);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] BCD_LAST = CNT_W'(ACC_W);

    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_MUL   = 2'b01;
    localparam logic [1:0] OP_SHOW  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // ADD is the single-cycle execute state: STORE, CLEAR, and any command
    // that arrives while err is set (those only produce a done pulse).
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        MUL  = 3'd2,
        FOLD = 3'd3,
        BCD  = 3'd4
    } state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [IN_W-1:0]    opnd_q;    // captured operand; doubles as multiplier shifter
    logic [PW-1:0]      mcand;     // multiplicand, shifted left each step
    logic [PW-1:0]      prod;      // partial product
    logic [CNT_W-1:0]   cnt;       // step counter for MUL and BCD
    logic [ACC_W-1:0]   bin_sr;    // binary value being shifted into BCD
    logic [BW-1:0]      bcd_sr;    // BCD digits under construction

    logic [SW-1:0]      sum;
    logic               sum_over;
    logic [PW-1:0]      prod_next;
    logic               prod_over;
    logic [BW-1:0]      bcd_adj;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;

    // Datapath helpers: fold sum, one multiply step, and the double-dabble
    // add-3 correction applied before each shift.
    always_comb begin
        sum       = {1'b0, total} + {1'b0, pending};
        sum_over  = (sum > LIMIT_S);
        prod_next = opnd_q[0] ? (prod + mcand) : prod;
        prod_over = (prod > LIMIT_P);
        bcd_adj   = bcd_sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_sr[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
            end
        end
    end

    // Sequencer FSM with all architectural registers and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_STORE;
            opnd_q    <= '0;
            mcand     <= '0;
            prod      <= '0;
            cnt       <= '0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            total     <= '0;
            pending   <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        opnd_q <= cmd_operand;
                        if (cmd_op == OP_CLEAR || err) begin
                            state <= ADD;
                        end else begin
                            case (cmd_op)
                                OP_STORE: state <= ADD;
                                OP_MUL: begin
                                    mcand <= PW'(pending);
                                    prod  <= '0;
                                    cnt   <= '0;
                                    state <= MUL;
                                end
                                default: state <= FOLD;
                            endcase
                        end
                    end
                end

                ADD: begin
                    if (op_q == OP_CLEAR) begin
                        total     <= '0;
                        pending   <= '0;
                        err       <= 1'b0;
                        bcd_out   <= '0;
                        bcd_valid <= 1'b0;
                    end else if (!err && op_q == OP_STORE) begin
                        // On overflow the total is kept; the new operand is
                        // still loaded into pending.
                        if (sum_over) begin
                            err <= 1'b1;
                        end else begin
                            total <= sum[ACC_W-1:0];
                        end
                        pending   <= ACC_W'(opnd_q);
                        bcd_valid <= 1'b0;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end

                MUL: begin
                    if (cnt == MUL_LAST) begin
                        if (prod_over) begin
                            err <= 1'b1;
                        end else begin
                            pending <= prod[ACC_W-1:0];
                        end
                        bcd_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        prod   <= prod_next;
                        mcand  <= mcand << 1;
                        opnd_q <= opnd_q >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end

                FOLD: begin
                    if (sum_over) begin
                        // Nothing to convert: finish immediately.
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        total     <= sum[ACC_W-1:0];
                        pending   <= '0;
                        bcd_valid <= 1'b0;
                        bin_sr    <= sum[ACC_W-1:0];
                        bcd_sr    <= '0;
                        cnt       <= '0;
                        state     <= BCD;
                    end
                end

                BCD: begin
                    if (cnt == BCD_LAST) begin
                        bcd_out   <= bcd_sr;
                        bcd_valid <= 1'b1;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        bcd_sr <= {bcd_adj[BW-2:0], bin_sr[ACC_W-1]};
                        bin_sr <= bin_sr << 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef CALC_SEG7_EN
    // Segment pattern (gfedcba, active-high) for one BCD nibble.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    logic       seg_lead;
    logic [3:0] seg_nib;

    // Display decode, scanning from the top digit so leading zeros blank;
    // the bottom digit is always shown and everything is dark while stale.
    always_comb begin
        seg_out  = '0;
        seg_lead = 1'b1;
        seg_nib  = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            seg_nib = bcd_out[4*d +: 4];
            if (seg_nib != 4'd0 || d == 0) begin
                seg_lead = 1'b0;
            end
            if (bcd_valid && !seg_lead) begin
                seg_out[7*d +: 7] = seg_of(seg_nib);
            end
        end
    end
`endif

endmodule
